// File: rtl/mrd_sink_gate_pkg.sv
// Shared types and widths for the mixed-radix DFT sink gate.
package mrd_sink_pkt;

  localparam int W_DATA = 18;  // real/imag sample width
  localparam int W_PTS  = 12;  // dftpts / counter width
  localparam int W_SIZE = 6;   // size index width

  // One buffered upstream beat; header fields are meaningful only with sop.
  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [W_DATA-1:0] re;
    logic [W_DATA-1:0] im;
    logic [W_PTS-1:0]  dftpts;
    logic [W_SIZE-1:0] size;
  } sink_word_t;

  localparam int W_WORD = $bits(sink_word_t);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_PAD,
    ST_DROP
  } gate_state_t;

endpackage

// File: rtl/mrd_sink_gate_if.sv
// Upstream sample stream, downstream packet stream and status of the sink gate.
interface mrd_sink_gate_if;
  import mrd_sink_pkt::*;

  logic              s_valid;
  logic              s_ready;
  logic              s_sop;
  logic              s_eop;
  logic [W_DATA-1:0] s_real;
  logic [W_DATA-1:0] s_imag;
  logic [W_PTS-1:0]  s_dftpts;
  logic [W_SIZE-1:0] s_size;

  logic              sink_ready;

  logic              m_valid;
  logic              m_sop;
  logic              m_eop;
  logic [W_DATA-1:0] m_real;
  logic [W_DATA-1:0] m_imag;
  logic [W_PTS-1:0]  m_dftpts;
  logic [W_SIZE-1:0] m_size;

  logic              err_short;
  logic              err_long;
  logic              busy;

  // The gate itself.
  modport slave (
    input  s_valid, s_sop, s_eop, s_real, s_imag, s_dftpts, s_size, sink_ready,
    output s_ready, m_valid, m_sop, m_eop, m_real, m_imag, m_dftpts, m_size,
    output err_short, err_long, busy
  );

  // The environment around the gate (sample source plus memory top).
  modport master (
    output s_valid, s_sop, s_eop, s_real, s_imag, s_dftpts, s_size, sink_ready,
    input  s_ready, m_valid, m_sop, m_eop, m_real, m_imag, m_dftpts, m_size,
    input  err_short, err_long, busy
  );

endinterface

// File: rtl/mrd_sink_fifo.sv
// Show-ahead FIFO: rd_data is the head word whenever empty is low.
// Flags come from the registered count; no write-to-read bypass.
module mrd_sink_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic         ready,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_d;
  logic          push;
  logic          pop;

  assign push    = wr_en & ready;
  assign pop     = rd_en & ~empty;
  assign empty   = (count == '0);
  assign count_d = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign rd_data = mem[rd_ptr];

  // Pointers, occupancy and the registered ready flag (held low in reset).
  // NOTE: state registers use <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_d;
      ready <= (count_d != FULL_CNT);
    end
  end

  // Storage array write port.
  // NOTE: the array has no reset; contents are only visible behind the reset count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mrd_sink_gate.sv
// Packet gate in front of the mixed-radix DFT memory top: waits for sink_ready,
// then emits sop plus exactly dftpts samples, padding or truncating as needed.
module mrd_sink_gate
  import mrd_sink_pkt::*;
#(
  parameter int DEPTH = 16
) (
  input logic            clk,
  input logic            rst,
  mrd_sink_gate_if.slave bus
);

  sink_word_t        in_word;
  sink_word_t        head;
  logic              fifo_empty;
  logic              fifo_ready;
  logic              pop;

  gate_state_t       state, state_d;
  logic [W_PTS-1:0]  cnt, cnt_d, cnt_inc;
  logic              orphan, orphan_d;

  logic              m_valid_q, m_valid_d;
  logic              m_sop_q, m_sop_d;
  logic              m_eop_q, m_eop_d;
  logic [W_DATA-1:0] m_real_q, m_real_d;
  logic [W_DATA-1:0] m_imag_q, m_imag_d;
  logic [W_PTS-1:0]  m_dftpts_q, m_dftpts_d;
  logic [W_SIZE-1:0] m_size_q, m_size_d;
  logic              err_short_q, err_short_d;
  logic              err_long_q, err_long_d;

  assign in_word = '{sop:    bus.s_sop,
                     eop:    bus.s_eop,
                     re:     bus.s_real,
                     im:     bus.s_imag,
                     dftpts: bus.s_dftpts,
                     size:   bus.s_size};

  mrd_sink_fifo #(
    .DEPTH (DEPTH),
    .W     (W_WORD)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.s_valid),
    .wr_data (in_word),
    .ready   (fifo_ready),
    .rd_en   (pop),
    .rd_data (head),
    .empty   (fifo_empty)
  );

  // cnt never exceeds dftpts, so this increment cannot wrap where it is used.
  assign cnt_inc = cnt + W_PTS'(1);

  // Next-state, pop decision and next output values.
  // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    orphan_d    = orphan;
    pop         = 1'b0;
    m_valid_d   = 1'b0;
    m_sop_d     = 1'b0;
    m_eop_d     = 1'b0;
    m_real_d    = m_real_q;
    m_imag_d    = m_imag_q;
    m_dftpts_d  = m_dftpts_q;
    m_size_d    = m_size_q;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (!head.sop) begin
            // Orphan beat: discard, flag only the first of a run.
            pop        = 1'b1;
            err_long_d = ~orphan;
            orphan_d   = 1'b1;
          end else begin
            orphan_d = 1'b0;
            if (head.dftpts < W_PTS'(2)) begin
              // Unsupported length: discard the header beat and the rest of the packet.
              pop        = 1'b1;
              err_long_d = 1'b1;
              if (!head.eop) state_d = ST_DROP;
            end else if (bus.sink_ready) begin
              pop        = 1'b1;
              m_valid_d  = 1'b1;
              m_sop_d    = 1'b1;
              m_real_d   = head.re;
              m_imag_d   = head.im;
              m_dftpts_d = head.dftpts;
              m_size_d   = head.size;
              cnt_d      = W_PTS'(1);
              if (head.eop) begin
                state_d     = ST_PAD;
                err_short_d = 1'b1;
              end else begin
                state_d = ST_STREAM;
              end
            end
          end
        end
      end

      ST_STREAM: begin
        orphan_d = 1'b0;
        if (!fifo_empty) begin
          if (head.sop) begin
            // Next packet arrived before this one ended: leave it queued and pad.
            state_d     = ST_PAD;
            err_short_d = 1'b1;
          end else begin
            pop       = 1'b1;
            m_valid_d = 1'b1;
            m_real_d  = head.re;
            m_imag_d  = head.im;
            cnt_d     = cnt_inc;
            if (cnt_inc == m_dftpts_q) begin
              m_eop_d = 1'b1;
              if (head.eop) begin
                state_d = ST_IDLE;
              end else begin
                state_d    = ST_DROP;
                err_long_d = 1'b1;
              end
            end else if (head.eop) begin
              state_d     = ST_PAD;
              err_short_d = 1'b1;
            end
          end
        end
      end

      ST_PAD: begin
        orphan_d  = 1'b0;
        m_valid_d = 1'b1;
        m_real_d  = '0;
        m_imag_d  = '0;
        cnt_d     = cnt_inc;
        if (cnt_inc == m_dftpts_q) begin
          m_eop_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_DROP: begin
        orphan_d = 1'b0;
        if (!fifo_empty) begin
          if (head.sop) begin
            state_d = ST_IDLE;
          end else begin
            pop = 1'b1;
            if (head.eop) state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, beat counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      orphan      <= 1'b0;
      m_valid_q   <= 1'b0;
      m_sop_q     <= 1'b0;
      m_eop_q     <= 1'b0;
      m_real_q    <= '0;
      m_imag_q    <= '0;
      m_dftpts_q  <= '0;
      m_size_q    <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      orphan      <= orphan_d;
      m_valid_q   <= m_valid_d;
      m_sop_q     <= m_sop_d;
      m_eop_q     <= m_eop_d;
      m_real_q    <= m_real_d;
      m_imag_q    <= m_imag_d;
      m_dftpts_q  <= m_dftpts_d;
      m_size_q    <= m_size_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
    end
  end

  assign bus.s_ready   = fifo_ready;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_sop     = m_sop_q;
  assign bus.m_eop     = m_eop_q;
  assign bus.m_real    = m_real_q;
  assign bus.m_imag    = m_imag_q;
  assign bus.m_dftpts  = m_dftpts_q;
  assign bus.m_size    = m_size_q;
  assign bus.err_short = err_short_q;
  assign bus.err_long  = err_long_q;
  assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_mrd_sink_gate.sv
// Self-checking bench for mrd_sink_gate: a packet-level model predicts the
// downstream beat sequence and error pulse totals; a monitor compares each beat.
module tb_mrd_sink_gate;
  import mrd_sink_pkt::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mrd_sink_gate_if bus ();

  mrd_sink_gate #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic              sop;
    logic              eop;
    logic [W_DATA-1:0] re;
    logic [W_DATA-1:0] im;
    logic [W_PTS-1:0]  pts;
    logic [W_SIZE-1:0] size;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;

  int tests = 0, fails = 0;
  int cyc = 0;
  int accepts = 0, first_acc_cyc = 0;
  int n_out = 0, first_out_cyc = -1;
  int obs_short = 0, obs_long = 0, exp_short = 0, exp_long = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Packet-level model: sop + exactly pts beats, data then zeros, eop on the last.
  task automatic model_pkt(input int pts, input int size, input int n, input int base);
    exp_t e;
    if (pts < 2) begin
      exp_long++;
      return;
    end
    for (int i = 0; i < pts; i++) begin
      e.sop  = (i == 0);
      e.eop  = (i == pts - 1);
      e.re   = (i < n) ? W_DATA'(base + i) : '0;
      e.im   = (i < n) ? W_DATA'(1000 + base + i) : '0;
      e.pts  = W_PTS'(pts);
      e.size = W_SIZE'(size);
      expq.push_back(e);
    end
    if (n < pts) exp_short++;
    if (n > pts) exp_long++;
  endtask

  // Compare process: every downstream beat and every error pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.err_short) obs_short++;
      if (bus.err_long)  obs_long++;
      if (bus.m_valid) begin
        n_out++;
        if (bus.m_sop && first_out_cyc < 0) first_out_cyc = cyc;
        if (expq.size() == 0) begin
          check("unexpected_m_valid", 32'(bus.m_valid), 0);
        end else begin
          mon_e = expq.pop_front();
          check("m_sop",    32'(bus.m_sop),    32'(mon_e.sop));
          check("m_eop",    32'(bus.m_eop),    32'(mon_e.eop));
          check("m_real",   32'(bus.m_real),   32'(mon_e.re));
          check("m_imag",   32'(bus.m_imag),   32'(mon_e.im));
          check("m_dftpts", 32'(bus.m_dftpts), 32'(mon_e.pts));
          check("m_size",   32'(bus.m_size),   32'(mon_e.size));
        end
      end
    end
  end

  task automatic push(input bit sop, input bit eop, input int re, input int im,
                      input int pts, input int size);
    int g = 0;
    @(negedge clk);
    bus.s_valid  = 1'b1;
    bus.s_sop    = sop;
    bus.s_eop    = eop;
    bus.s_real   = W_DATA'(re);
    bus.s_imag   = W_DATA'(im);
    bus.s_dftpts = W_PTS'(pts);
    bus.s_size   = W_SIZE'(size);
    while (!bus.s_ready) begin
      @(negedge clk);
      g++;
      if (g > 2000) begin
        check("s_ready_timeout", 32'(bus.s_ready), 1);
        break;
      end
    end
    if (sop) first_acc_cyc = cyc;
    @(posedge clk);
    accepts++;
  endtask

  task automatic idle_in();
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_sop   = 1'b0;
    bus.s_eop   = 1'b0;
  endtask

  task automatic send_pkt(input int pts, input int size, input int n, input int base);
    for (int i = 0; i < n; i++)
      push(i == 0, i == n - 1, base + i, 1000 + base + i, (i == 0) ? pts : 0, (i == 0) ? size : 0);
    idle_in();
  endtask

  task automatic drain();
    int g = 0;
    while (expq.size() != 0 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("drain_remaining", expq.size(), 0);
    repeat (4) @(negedge clk);
    check("err_short_total", obs_short, exp_short);
    check("err_long_total",  obs_long,  exp_long);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, s0, l0, seen;
    bus.s_valid = 1'b0; bus.s_sop = 1'b0; bus.s_eop = 1'b0;
    bus.s_real = '0; bus.s_imag = '0; bus.s_dftpts = '0; bus.s_size = '0;
    bus.sink_ready = 1'b0;

    // Reset state: every output low, s_ready rises one edge after release.
    #2;
    check("rst_ctrl", {bus.m_valid, bus.m_sop, bus.m_eop, bus.err_short, bus.err_long, bus.busy, bus.s_ready}, 0);
    check("rst_data", 32'(bus.m_real) | 32'(bus.m_imag) | 32'(bus.m_dftpts) | 32'(bus.m_size), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("s_ready_before_edge", 32'(bus.s_ready), 0);
    @(posedge clk);
    #1 check("s_ready_after_edge", 32'(bus.s_ready), 1);

    // Nominal 12-point packet, 2-cycle minimum latency.
    bus.sink_ready = 1'b1;
    n0 = n_out; s0 = obs_short; l0 = obs_long; first_out_cyc = -1;
    model_pkt(12, 3, 12, 1);
    send_pkt(12, 3, 12, 1);
    drain();
    check("nom_count", n_out - n0, 12);
    check("nom_latency", first_out_cyc - first_acc_cyc, 2);
    check("nom_no_short", obs_short - s0, 0);
    check("nom_no_long", obs_long - l0, 0);

    // Back-pressure: 24-point packet held while sink_ready is low.
    bus.sink_ready = 1'b0;
    n0 = n_out; accepts = 0;
    model_pkt(24, 5, 24, 100);
    fork
      send_pkt(24, 5, 24, 100);
      begin
        for (int g = 0; g < 300 && bus.s_ready; g++) @(negedge clk);
        check("bp_ready_low", 32'(bus.s_ready), 0);
        check("bp_accepts", accepts, 16);
        check("bp_no_output", n_out - n0, 0);
        repeat (5) @(negedge clk);
        check("bp_still_held", accepts, 16);
        check("bp_still_no_output", n_out - n0, 0);
        bus.sink_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", n_out - n0, 24);

    // Short packet: eop on beat 9 of 12, three zero beats appended.
    n0 = n_out; s0 = obs_short;
    model_pkt(12, 2, 9, 200);
    send_pkt(12, 2, 9, 200);
    drain();
    check("short_count", n_out - n0, 12);
    check("short_pulses", obs_short - s0, 1);

    // Long packet: 15 beats truncated to 12, then a normal packet follows.
    n0 = n_out; l0 = obs_long;
    model_pkt(12, 4, 15, 300);
    model_pkt(12, 4, 12, 400);
    send_pkt(12, 4, 15, 300);
    send_pkt(12, 4, 12, 400);
    drain();
    check("long_count", n_out - n0, 24);
    check("long_pulses", obs_long - l0, 1);

    // Orphan beats, a zero-length packet, then a valid packet.
    n0 = n_out; l0 = obs_long;
    exp_long++;
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 50 + i, 60 + i, 0, 0);
    model_pkt(0, 1, 3, 700);
    send_pkt(0, 1, 3, 700);
    model_pkt(12, 6, 12, 800);
    send_pkt(12, 6, 12, 800);
    drain();
    check("orphan_count", n_out - n0, 12);
    check("orphan_pulses", obs_long - l0, 2);

    // Reset in the middle of a stream, at output beat 5.
    bus.sink_ready = 1'b0;
    model_pkt(12, 7, 12, 500);
    send_pkt(12, 7, 12, 500);
    bus.sink_ready = 1'b1;
    seen = 0;
    for (int g = 0; g < 200 && seen < 5; g++) begin
      @(posedge clk);
      #1 if (bus.m_valid) seen++;
    end
    check("mid_reached_5", seen, 5);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("mid_rst_ctrl", {bus.m_valid, bus.m_sop, bus.m_eop, bus.err_short, bus.err_long, bus.busy, bus.s_ready}, 0);
    check("mid_rst_data", 32'(bus.m_real) | 32'(bus.m_imag) | 32'(bus.m_dftpts) | 32'(bus.m_size), 0);
    expq.delete();
    repeat (2) @(negedge clk);
    check("mid_rst_held", {bus.m_valid, bus.m_eop, bus.busy, bus.s_ready}, 0);
    rst = 1'b0;
    #1 check("mid_ready_before_edge", 32'(bus.s_ready), 0);
    n0 = n_out;
    repeat (6) @(negedge clk);
    check("mid_fifo_empty", n_out - n0, 0);
    check("mid_idle", 32'(bus.busy), 0);
    model_pkt(12, 3, 12, 900);
    send_pkt(12, 3, 12, 900);
    drain();
    check("mid_after_count", n_out - n0, 12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
